// File: rtl/clk_div_multi_if.sv
// Control/status bundle for clk_div_multi: per-channel enables, the global
// sync pulse, the divisor write port and the per-channel tick/clk_out/div_q
// outputs. NUM_CH and CNT_W must match the divider instance.
interface clk_div_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       en;
  logic                    sync;
  logic                    wr_en;
  logic [CH_W-1:0]         wr_ch;
  logic [CNT_W-1:0]        wr_div;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH*CNT_W-1:0] div_q;

  // Controller side: drives enables, sync and writes; observes the dividers.
  modport master (
    output en, sync, wr_en, wr_ch, wr_div,
    input  tick, clk_out, div_q
  );

  // Divider side.
  modport slave (
    input  en, sync, wr_en, wr_ch, wr_div,
    output tick, clk_out, div_q
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable tick/clock divider. Each channel counts
// 0..div-1 and on wrap emits a one-cycle tick and toggles a 50 % clk_out.
// Consumers should use tick as a clock enable, not clk_out as a clock.
module clk_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 5000
) (
  input  logic            clk,
  input  logic            rst,
  clk_div_multi_if.slave  bus
);

  localparam int              CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_DEFAULT = CNT_W'(DEFAULT_DIV);

  // A zero divisor would never wrap, so it is promoted to 1.
  logic [CNT_W-1:0]        w_wr_val;
  logic [NUM_CH-1:0]       w_tick;
  logic [NUM_CH-1:0]       w_clk_out;
  logic [NUM_CH*CNT_W-1:0] w_div_q;

  assign w_wr_val = (bus.wr_div == '0) ? C_ONE : bus.wr_div;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_count;
    logic             r_tick;
    logic             r_clk_out;
    logic             w_wr_hit;
    logic             w_at_wrap;

    // Indices at or above NUM_CH match no channel, so such writes are dropped.
    assign w_wr_hit  = bus.wr_en && (bus.wr_ch == CH_W'(gi));
    // div is always >= 1, so div-1 cannot underflow.
    assign w_at_wrap = (r_count == r_div - C_ONE);

    // Per-channel divider: rst > sync > write > count; divisor write also lands under sync.
    // NOTE: sequential state uses non-blocking (<=) so every channel samples
    // the pre-edge values of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_div     <= C_DEFAULT;
        r_count   <= '0;
        r_tick    <= 1'b0;
        r_clk_out <= 1'b0;
      end else begin
        if (w_wr_hit) begin
          r_div <= w_wr_val;
        end
        if (bus.sync) begin
          r_count   <= '0;
          r_tick    <= 1'b0;
          r_clk_out <= 1'b0;
        end else if (w_wr_hit) begin
          r_count <= '0;
          r_tick  <= 1'b0;
        end else if (bus.en[gi]) begin
          if (w_at_wrap) begin
            r_count   <= '0;
            r_tick    <= 1'b1;
            r_clk_out <= ~r_clk_out;
          end else begin
            r_count <= r_count + C_ONE;
            r_tick  <= 1'b0;
          end
        end else begin
          r_tick <= 1'b0;
        end
      end
    end

    assign w_tick[gi]                   = r_tick;
    assign w_clk_out[gi]                = r_clk_out;
    assign w_div_q[gi*CNT_W +: CNT_W]   = r_div;
  end

  assign bus.tick    = w_tick;
  assign bus.clk_out = w_clk_out;
  assign bus.div_q   = w_div_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: 3 channels, 16-bit counters, reset
// divisor 4. Inputs change 1 ns after each rising edge; outputs are checked
// at the same point, i.e. they reflect the edge just taken.
module tb_clk_div_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  clk_div_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clk_div_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] ch, input logic [CNT_W-1:0] val);
    bus.wr_en  = 1'b1;
    bus.wr_ch  = ch;
    bus.wr_div = val;
  endtask

  task automatic clear_ctl();
    bus.wr_en  = 1'b0;
    bus.wr_ch  = '0;
    bus.wr_div = '0;
    bus.sync   = 1'b0;
  endtask

  initial begin
    bus.en = 3'b111;
    clear_ctl();

    // Reset defaults.
    step();
    step();
    check("rst_tick",  64'(bus.tick),    64'd0);
    check("rst_clk",   64'(bus.clk_out), 64'd0);
    check("rst_div_q", 64'(bus.div_q),   {16'd4, 16'd4, 16'd4});
    rst = 1'b0;

    // Default cadence: ticks after edges 4, 8, 12; clk_out rises at 4, falls at 8.
    for (int k = 1; k <= 12; k++) begin
      step();
      check("def_tick", 64'(bus.tick),    (k % 4 == 0) ? 64'h7 : 64'h0);
      check("def_clk",  64'(bus.clk_out), ((k / 4) % 2 == 1) ? 64'h7 : 64'h0);
    end

    // Runtime write of ch1 div=3 mid-period of ch0 (edge 15 since reset release).
    step();
    step();
    write(2'd1, 16'd3);
    step();
    clear_ctl();
    check("wr_div_q",     64'(bus.div_q),      {16'd4, 16'd3, 16'd4});
    check("wr_tick1",     64'(bus.tick[1]),    64'd0);
    check("wr_clk1_hold", 64'(bus.clk_out[1]), 64'd1);
    for (int j = 1; j <= 9; j++) begin
      int e;
      e = 15 + j;
      step();
      check("wr_tick0", 64'(bus.tick[0]),    (e % 4 == 0) ? 64'd1 : 64'd0);
      check("wr_clk0",  64'(bus.clk_out[0]), ((e / 4) % 2 == 1) ? 64'd1 : 64'd0);
      check("wr_tick1", 64'(bus.tick[1]),    (j % 3 == 0) ? 64'd1 : 64'd0);
      check("wr_clk1",  64'(bus.clk_out[1]), ((j / 3) % 2 == 1) ? 64'd0 : 64'd1);
    end

    // Zero divisor on ch0 is promoted to 1.
    write(2'd0, 16'd0);
    step();
    clear_ctl();
    check("zero_div_q", 64'(bus.div_q),      {16'd4, 16'd3, 16'd1});
    check("zero_tick0", 64'(bus.tick[0]),    64'd0);
    check("zero_clk0",  64'(bus.clk_out[0]), 64'd0);
    for (int j = 1; j <= 4; j++) begin
      step();
      check("div1_tick0", 64'(bus.tick[0]),    64'd1);
      check("div1_clk0",  64'(bus.clk_out[0]), (j % 2 == 1) ? 64'd1 : 64'd0);
    end

    // Enable gating: ch0 div=4, hold en0 low for 5 cycles at count=2.
    write(2'd0, 16'd4);
    step();
    clear_ctl();
    check("gate_div_q", 64'(bus.div_q),      {16'd4, 16'd3, 16'd4});
    check("gate_clk0",  64'(bus.clk_out[0]), 64'd0);
    step();
    step();
    check("gate_pre_tick0", 64'(bus.tick[0]), 64'd0);
    bus.en = 3'b110;
    for (int j = 1; j <= 5; j++) begin
      step();
      check("gate_off_tick0", 64'(bus.tick[0]),    64'd0);
      check("gate_off_clk0",  64'(bus.clk_out[0]), 64'd0);
    end
    bus.en = 3'b111;
    step();
    check("gate_cnt3_tick0", 64'(bus.tick[0]),    64'd0);
    step();
    check("gate_wrap_tick0", 64'(bus.tick[0]),    64'd1);
    check("gate_wrap_clk0",  64'(bus.clk_out[0]), 64'd1);

    // Sync alignment: ch1 div=8, sync arrives on the edge ch0 would wrap.
    write(2'd1, 16'd8);
    step();
    clear_ctl();
    step();
    step();
    check("sync_pre_clk0", 64'(bus.clk_out[0]), 64'd1);
    bus.sync = 1'b1;
    step();
    clear_ctl();
    check("sync_clk",   64'(bus.clk_out), 64'd0);
    check("sync_tick",  64'(bus.tick),    64'd0);
    check("sync_div_q", 64'(bus.div_q),   {16'd4, 16'd8, 16'd4});
    for (int k = 1; k <= 8; k++) begin
      step();
      check("sync_tick0", 64'(bus.tick[0]),    (k % 4 == 0) ? 64'd1 : 64'd0);
      check("sync_clk0",  64'(bus.clk_out[0]), ((k / 4) % 2 == 1) ? 64'd1 : 64'd0);
      check("sync_tick1", 64'(bus.tick[1]),    (k == 8) ? 64'd1 : 64'd0);
      check("sync_clk1",  64'(bus.clk_out[1]), (k == 8) ? 64'd1 : 64'd0);
    end

    // Priority: rst + sync + write -> reset wins.
    rst      = 1'b1;
    bus.sync = 1'b1;
    write(2'd1, 16'd9);
    step();
    rst = 1'b0;
    clear_ctl();
    check("prio_rst_div_q", 64'(bus.div_q),   {16'd4, 16'd4, 16'd4});
    check("prio_rst_tick",  64'(bus.tick),    64'd0);
    check("prio_rst_clk",   64'(bus.clk_out), 64'd0);
    for (int k = 1; k <= 4; k++) step();
    check("prio_pre_clk", 64'(bus.clk_out), 64'h7);

    // sync + write: divisor updates, counts restart, clk_out cleared.
    bus.sync = 1'b1;
    write(2'd1, 16'd7);
    step();
    clear_ctl();
    check("prio_sw_div_q", 64'(bus.div_q),   {16'd4, 16'd7, 16'd4});
    check("prio_sw_clk",   64'(bus.clk_out), 64'd0);
    check("prio_sw_tick",  64'(bus.tick),    64'd0);
    for (int k = 1; k <= 8; k++) begin
      // Out-of-range channel write on edge 8 must change nothing.
      if (k == 8) write(2'd3, 16'd9);
      step();
      clear_ctl();
      check("prio_tick0", 64'(bus.tick[0]), (k % 4 == 0) ? 64'd1 : 64'd0);
      check("prio_tick1", 64'(bus.tick[1]), (k == 7) ? 64'd1 : 64'd0);
      check("prio_tick2", 64'(bus.tick[2]), (k % 4 == 0) ? 64'd1 : 64'd0);
    end
    check("badch_div_q", 64'(bus.div_q),   {16'd4, 16'd7, 16'd4});
    check("badch_clk",   64'(bus.clk_out), 64'b010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
